sst_dump_reader: RTL



---
 rtl/sst_dump_reader.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/sst_dump_reader.sv
// sst_dump_reader
//
// Streams a contiguous range of the 13-bit save-state (SST) address space out
// as bytes. A start pulse latches base_addr and len. The block then issues
// pipelined reads into the SST read port, pushes the returned bytes into a
// small output FIFO and presents them in address order on a valid/ready
// stream. The MCU can pull a whole snapshot without setting up each address.
//
// Build option:
//   SST_DUMP_CSUM_EN  when defined, csum is the mod-256 sum of accepted bytes.
//                     It is cleared on start and holds after done or abort.
//                     When undefined, csum is tied to zero.
//
// Parameters:
//   RD_LAT      SST read latency in cycles, from rd_en to rd_data (1..3)
//   FIFO_DEPTH  output buffer depth (power of 2, at least RD_LAT+2)
//
// Ports:
//   clk        system clock
//   sys_rst    synchronous active-high reset
//   start      one-cycle command pulse; only accepted in IDLE
//   abort      cancels a dump in progress (no done pulse)
//   base_addr  first SST address, sampled on start
//   len        byte count 0..8192, sampled on start
//   rd_en      SST read strobe
//   rd_addr    SST read address, valid while rd_en is high
//   rd_data    SST read data, RD_LAT cycles after rd_en
//   out_data   stream byte
//   out_valid  stream byte valid
//   out_ready  consumer accepts when out_valid and out_ready are both high
//   busy       high from the cycle after start until done
//   done       one-cycle pulse on normal completion
//   csum       running checksum of accepted bytes
module sst_dump_reader #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        abort,
  input  logic [12:0] base_addr,
  input  logic [13:0] len,
  output logic        rd_en,
  output logic [12:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  csum
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = AW + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t             state_q;
  logic [12:0]        addr_q;
  logic [13:0]        remain_q;
  logic               rd_en_q;
  logic [12:0]        rd_addr_q;
  logic               busy_q;
  logic               done_q;
  logic [RD_LAT-1:0]  pipe_q;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [CNTW-1:0]    count_q;

  logic               pop;
  logic               push;
  logic               flush;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      tokens;
  logic               credit_ok;
  logic               drain_done;

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign pop       = out_valid & out_ready;
  assign push      = pipe_q[RD_LAT-1];
  assign flush     = abort && (state_q != IDLE);

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Reads in flight: the one on the port this cycle plus those in the
  // latency pipe. A byte moving from the pipe into the FIFO is counted once.
  always_comb begin
    inflight = CW'(rd_en_q);
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pipe_q[i]);
    end
  end

  assign tokens = CW'(count_q) + inflight;

  // rd_en is registered, so the decision made now covers next cycle. A byte
  // popped this cycle frees its slot in time for that read; counting it keeps
  // the stream bubble-free at the minimum FIFO depth.
  assign credit_ok = tokens < (CW'(FIFO_DEPTH) + CW'(pop));

  // Nothing in flight and the FIFO either empty or losing its last byte now.
  assign drain_done = (inflight == '0) &&
                      ((count_q == '0) || ((count_q == CNTW'(1)) && pop));

  // Control FSM with registered read strobe, address and status outputs
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              // The FIFO is empty in IDLE, so the first read can go out
              // in the very next cycle.
              state_q   <= RUN;
              busy_q    <= 1'b1;
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_addr;
              addr_q    <= base_addr + 13'd1;
              remain_q  <= len - 14'd1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (remain_q == '0) begin
            state_q <= DRAIN;
          end else if (credit_ok) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= addr_q;
            addr_q    <= addr_q + 13'd1;
            remain_q  <= remain_q - 14'd1;
            if (remain_q == 14'd1) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (drain_done) begin
            state_q <= FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency pipe: one valid bit per read in flight
  always_ff @(posedge clk) begin
    if (sys_rst || flush) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= rd_en_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (sys_rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  // Output FIFO storage; pointers decide what is valid, so no reset here
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rd_data;
    end
  end

`ifdef SST_DUMP_CSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      csum_q <= 8'h00;
    end else if ((state_q == IDLE) && start) begin
      csum_q <= 8'h00;
    end else if (pop && !flush) begin
      csum_q <= csum_q + out_data;
    end
  end

  assign csum = csum_q;
`else
  assign csum = 8'h00;
`endif

endmodule
